// File: rtl/polynomial_taps_loader.sv
// Shadow bank of G_POLY_ORDER+1 coefficients streamed over valid/ready into the estimator's tap port.
// Optional WAIT_DONE timeout with sticky load_error when POLY_TAPS_LOADER_TIMEOUT_EN is defined.
module polynomial_taps_loader #(
    parameter int G_POLY_ORDER = 5,
    localparam int C_N = G_POLY_ORDER + 1,
    localparam int C_FP_DWIDTH = 32,
    localparam int C_ADDR_WIDTH = (C_N > 1) ? $clog2(C_N) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    coef_wr_en,
    input  logic [C_ADDR_WIDTH-1:0] coef_wr_addr,
    input  logic [C_FP_DWIDTH-1:0]  coef_wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_error,
    output logic [C_FP_DWIDTH-1:0]  taps_prog_din,
    output logic                    taps_prog_din_valid,
    input  logic                    taps_prog_din_ready,
    input  logic                    taps_prog_done
);

    // state      | meaning
    // ST_IDLE    | bank writable, waiting for start
    // ST_SEND    | streaming taps 0..N-1, valid held high
    // ST_WAIT_DONE | all taps sent, waiting for the estimator's done level
    // ST_ERROR   | done never arrived in time; sticky until start or reset
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE
`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
        , ST_ERROR
`endif
    } state_t;

    localparam logic [C_ADDR_WIDTH-1:0] C_LAST_IDX = C_ADDR_WIDTH'(C_N - 1);
    localparam logic [C_ADDR_WIDTH:0]   C_N_EXT    = (C_ADDR_WIDTH + 1)'(C_N);

    state_t                   state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [C_FP_DWIDTH-1:0]   din_q, din_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic [C_FP_DWIDTH-1:0]   bank_q [C_N];

    logic                     wr_hit;
    logic                     launch;
    logic                     hs;
    logic [C_ADDR_WIDTH-1:0]  idx_next;
    logic [C_FP_DWIDTH-1:0]   first_tap;

`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
    localparam logic [15:0] C_TMO_LAST = 16'd4095;
    logic        err_q, err_d;
    logic [15:0] tmo_q, tmo_d;
`endif

    assign wr_hit   = coef_wr_en && ({1'b0, coef_wr_addr} < C_N_EXT) && (state_q == ST_IDLE);
    assign hs       = valid_q && taps_prog_din_ready;
    assign idx_next = idx_q + 1'b1;

    // A write to entry 0 in the start cycle must reach the first tap.
    assign first_tap = (wr_hit && (coef_wr_addr == '0)) ? coef_wr_data : bank_q[0];

`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
    assign launch = enable && start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
`else
    assign launch = enable && start && (state_q == ST_IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_N; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_hit) begin
            bank_q[coef_wr_addr] <= coef_wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        din_d   = din_q;
        valid_d = valid_q;
        done_d  = 1'b0;
`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
        err_d   = err_q;
        tmo_d   = tmo_q;
`endif
        if (launch) begin
            idx_d   = '0;
            din_d   = first_tap;
            valid_d = 1'b1;
            state_d = ST_SEND;
`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end else if (enable) begin
            case (state_q)
                ST_SEND: begin
                    if (hs) begin
                        if (idx_q == C_LAST_IDX) begin
                            valid_d = 1'b0;
                            state_d = ST_WAIT_DONE;
`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
                            tmo_d   = '0;
`endif
                        end else begin
                            idx_d = idx_next;
                            din_d = bank_q[idx_next];
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (taps_prog_done) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
                    end else if (tmo_q == C_TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            din_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef POLY_TAPS_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end

    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

    assign busy                = (state_q != ST_IDLE);
    assign load_done           = done_q;
    assign taps_prog_din       = din_q;
    assign taps_prog_din_valid = valid_q;

endmodule

// File: doc/polynomial_taps_loader.md
# polynomial_taps_loader

Initiator side of the polynomial estimator's tap-programming stream. Holds a shadow bank of G_POLY_ORDER+1 single-precision coefficients written from the control plane. On a start pulse it streams them in order over a valid/ready interface into the estimator's `taps_prog_din*` port, then waits for the estimator's `taps_prog_done`. Sits between the register block and the polynomial estimator wrapper.

## Interface
- G_POLY_ORDER, 5, polynomial order; tap count N = G_POLY_ORDER+1
- C_FP_DWIDTH, 32 (localparam), coefficient width, IEEE-754 single
- C_ADDR_WIDTH, $clog2(N) (localparam, minimum 1), coefficient address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  when low, state, counters and outputs freeze; the shadow bank still accepts writes
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  C_ADDR_WIDTH  tap index; values >= N ignored
- coef_wr_data  in  32  coefficient value
- start  in  1  single-cycle load request
- busy  out  1  high outside IDLE
- load_done  out  1  one-cycle pulse on successful completion
- load_error  out  1  sticky timeout flag (macro only; tied 0 otherwise)
- taps_prog_din  out  32  tap data
- taps_prog_din_valid  out  1  tap valid
- taps_prog_din_ready  in  1  sink ready
- taps_prog_done  in  1  level from the estimator: all taps received

## Operation
- Shadow bank: N x 32 registers.
  - Reset clears every entry to 0x00000000.
  - A write at an in-range address updates the entry when `busy`=0.
  - Writes while `busy`=1 are dropped, so a load in progress always sends a consistent set.
- FSM states: IDLE, SEND, WAIT_DONE, plus ERROR when the macro is enabled.
- IDLE:
  - `start`=1 with `enable`=1: tap index clears to 0, `taps_prog_din` loads bank[0], valid goes high, next state SEND.
  - `load_error` clears on this start.
- SEND:
  - Handshake = valid & ready.
  - On a handshake at index < N-1: the index increments and `taps_prog_din` loads bank[index+1] in the same edge, so valid stays high back-to-back.
  - On a handshake at index N-1: valid drops and the next state is WAIT_DONE.
  - While ready is low, data and valid hold stable.
- WAIT_DONE:
  - The first cycle that samples `taps_prog_done`=1 pulses `load_done` and returns to IDLE.
- `start` outside IDLE is ignored; no queuing.
- Tap order: index 0 first, index N-1 last. Data passes through unmodified, with no float interpretation.
- `taps_prog_done` is ignored outside WAIT_DONE.

## Timing
- Reset values:
  - `busy`=0, `load_done`=0, `load_error`=0
  - `taps_prog_din_valid`=0, `taps_prog_din`=0
  - state IDLE, index 0
- `start` at cycle t: valid=1 with bank[0] at cycle t+1, and `busy`=1 from t+1.
- With ready held high, tap k transfers at cycle t+1+k. The last tap transfers at t+N.
- WAIT_DONE is entered at t+N+1. If done is high there, `load_done` pulses at t+N+2 and `busy`=0 at t+N+2.
- `enable`=0 on any cycle:
  - No state change and no handshake is counted, even if ready=1.
  - valid and data hold.
  - `load_done` does not pulse.
- A write to bank[k] in the same cycle as `start`: the write lands, and the load uses the new value.
- `reset` mid-SEND or mid-WAIT_DONE: next cycle valid=0, IDLE, bank cleared. Partial taps in the sink are its own concern.
- `coef_wr_addr` >= N (possible when N is not a power of two): no effect.

## Configuration
- POLY_TAPS_LOADER_TIMEOUT_EN:
  - Defined: a 16-bit counter runs in WAIT_DONE and clears on WAIT_DONE entry. If `taps_prog_done` has not been seen after 4096 cycles in WAIT_DONE, the FSM enters ERROR with `load_error`=1 and `busy`=1.
  - ERROR leaves only on reset, or on `start`, which clears the error and begins a new load.
  - Enable gating applies to the counter.
  - Undefined: no counter and no ERROR state. WAIT_DONE waits indefinitely, and `load_error` is constant 0.

## Test plan
- Write bank = {0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000}, start, ready=1, done rises 2 cycles after the last tap -> six taps in order on six consecutive cycles; `load_done` pulses once; `busy` falls together with the pulse.
- Same load with ready toggling 1,0,0,1 repeating -> every tap held stable while ready=0; exactly six handshakes; data order unchanged.
- Write bank[2]=0xDEADBEEF while busy, then start a second load -> bank[2] in the second load still shows its pre-write value (0x40400000).
- Reset asserted after the third handshake -> valid=0 next cycle, `busy`=0, bank all zero; a fresh start sends six 0x00000000 taps.
- `enable`=0 for 5 cycles mid-SEND with ready=1 -> no index advance; the tap sequence resumes intact.
- With POLY_TAPS_LOADER_TIMEOUT_EN and done held 0 -> `load_error`=1 exactly 4096 cycles after WAIT_DONE entry; the next start clears it and reloads.
